// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch controller with 2-entry prefetch buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] STOP_WORD = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, w0_q, w0_d;
  logic [31:0] pc1_q, pc1_d, w1_q, w1_d;
  logic        pop, flush, fetch, is_stop, push;
  logic [1:0]  fill;

  assign instr_valid = (count_q != 2'd0);
  assign instr       = w0_q;
  assign instr_pc    = pc0_q;
  assign rom_addr    = fetch_pc_q;
  assign halted      = (state_q == S_HALT) && (count_q == 2'd0);

  assign pop     = instr_valid && instr_ready;
  assign flush   = redirect_valid && (state_q != S_IDLE);
  assign fetch   = (state_q == S_FETCH) && !redirect_valid && ((count_q != 2'd2) || pop);
  assign is_stop = fetch && (rom_data == STOP_WORD);
  assign push    = fetch && !is_stop;
  assign rom_en  = fetch;
  // Slot the new word lands in once this cycle's pop has been accounted for.
  assign fill    = count_q - {1'b0, pop};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    w0_d       = w0_q;
    pc1_d      = pc1_q;
    w1_d       = w1_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (flush) state_d = S_FETCH; else if (is_stop) state_d = S_HALT;
      S_HALT:  if (flush) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    // Flush only clears the count so the head keeps showing its last value.
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && (count_q == 2'd2)) begin
        pc0_d = pc1_q;
        w0_d  = w1_q;
      end
      if (push) begin
        if (fill == 2'd0) begin
          pc0_d = fetch_pc_q;
          w0_d  = rom_data;
        end else begin
          pc1_d = fetch_pc_q;
          w1_d  = rom_data;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      pc0_q      <= 32'd0;
      w0_q       <= 32'd0;
      pc1_q      <= 32'd0;
      w1_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      w0_q       <= w0_d;
      pc1_q      <= pc1_d;
      w1_q       <= w1_d;
    end
  end

endmodule
